// File: rtl/i2c_bit_ctrl.sv
// Bit-level I2C engine: runs one START, STOP, WRITE or READ bit per command as
// four quarter-bit phases, driving open-drain SCL/SDA enables. PH_B waits for
// SCL to read back high, so a slave can stretch the clock. Arbitration loss
// aborts the command and releases both lines.
module i2c_bit_ctrl #(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd,
  input  logic       tx_bit,
  output logic       done,
  output logic       rx_bit,
  output logic       arb_lost,
  output logic       busy,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe,
  output logic       sda_oe
);

  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam logic [CntW-1:0] CntLoad = CntW'(CLK_DIV - 1);

  typedef enum logic [2:0] {StIdle, StPhA, StPhB, StPhC, StPhD} state_e;
  typedef enum logic [1:0] {OpStart, OpStop, OpWrite, OpRead} op_e;

  state_e          state_q;
  state_e          next_ph;
  op_e             op_q;
  op_e             op_in;
  logic            tx_q;
  logic [CntW-1:0] cnt_q;
  logic            scl_meta_q, scl_s;
  logic            sda_meta_q, sda_s;
  logic            cmd_is_op;
  logic [2:0]      cmd_m1;
  logic            phase_end;
  logic            arb_hit;

  // Line enables for a given command and phase, returned as {scl_oe, sda_oe}.
  // START leaves SCL untouched in PH_A so a repeated START keeps SCL low.
  function automatic logic [1:0] drive(op_e op, logic txb, state_e ph, logic scl_cur);
    logic scl_n;
    logic sda_n;
    scl_n = 1'b0;
    sda_n = 1'b0;
    unique case (op)
      OpStart: begin
        scl_n = (ph == StPhA) ? scl_cur : (ph == StPhD);
        sda_n = (ph == StPhC) || (ph == StPhD);
      end
      OpStop: begin
        scl_n = (ph == StPhA);
        sda_n = (ph == StPhA) || (ph == StPhB);
      end
      OpWrite: begin
        scl_n = (ph == StPhA) || (ph == StPhD);
        sda_n = ~txb;
      end
      OpRead: begin
        scl_n = (ph == StPhA) || (ph == StPhD);
        sda_n = 1'b0;
      end
      default: ;
    endcase
    return {scl_n, sda_n};
  endfunction

  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);

  // Command decode: 1..4 map onto the four operations, anything else is a NOP.
  assign cmd_m1    = cmd - 3'd1;
  assign op_in     = op_e'(cmd_m1[1:0]);
  assign cmd_is_op = (cmd >= 3'd1) && (cmd <= 3'd4);

  // Phase timing and arbitration detection from the synchronized pad values.
  always_comb begin
    phase_end = (cnt_q == '0) && ((state_q != StPhB) || scl_s);
    arb_hit   = 1'b0;
    if (!sda_oe && !sda_s) begin
      unique case (state_q)
        StPhB:   arb_hit = (op_q == OpStart) && phase_end;
        StPhC:   arb_hit = (op_q == OpWrite) && tx_q;
        StPhD:   arb_hit = (op_q == OpStop);
        default: arb_hit = 1'b0;
      endcase
    end
  end

  // Phase successor for the A->B->C->D walk.
  always_comb begin
    next_ph = StIdle;
    unique case (state_q)
      StPhA:   next_ph = StPhB;
      StPhB:   next_ph = StPhC;
      StPhC:   next_ph = StPhD;
      default: next_ph = StIdle;
    endcase
  end

  // Two-stage synchronizers for the asynchronous pad inputs; idle bus is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_meta_q <= 1'b1;
      scl_s      <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_s      <= 1'b1;
    end else begin
      scl_meta_q <= scl_i;
      scl_s      <= scl_meta_q;
      sda_meta_q <= sda_i;
      sda_s      <= sda_meta_q;
    end
  end

  // Command FSM with registered line enables and status pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      op_q     <= OpStart;
      tx_q     <= 1'b0;
      cnt_q    <= '0;
      scl_oe   <= 1'b0;
      sda_oe   <= 1'b0;
      done     <= 1'b0;
      arb_lost <= 1'b0;
      rx_bit   <= 1'b0;
    end else begin
      done     <= 1'b0;
      arb_lost <= 1'b0;
      if (arb_hit) begin
        state_q  <= StIdle;
        scl_oe   <= 1'b0;
        sda_oe   <= 1'b0;
        arb_lost <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (cmd_valid) begin
              if (cmd_is_op) begin
                op_q             <= op_in;
                tx_q             <= tx_bit;
                cnt_q            <= CntLoad;
                state_q          <= StPhA;
                {scl_oe, sda_oe} <= drive(op_in, tx_bit, StPhA, scl_oe);
              end else begin
                done <= 1'b1;
              end
            end
          end
          StPhA, StPhB, StPhC: begin
            if (phase_end) begin
              state_q          <= next_ph;
              cnt_q            <= CntLoad;
              {scl_oe, sda_oe} <= drive(op_q, tx_q, next_ph, scl_oe);
              if ((state_q == StPhC) && ((op_q == OpWrite) || (op_q == OpRead))) begin
                rx_bit <= sda_s;
              end
            end else if (cnt_q != '0) begin
              cnt_q <= cnt_q - CntW'(1);
            end
          end
          StPhD: begin
            if (phase_end) begin
              state_q <= StIdle;
              done    <= 1'b1;
            end else if (cnt_q != '0) begin
              cnt_q <= cnt_q - CntW'(1);
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule
